clock_alarm_core: RTL and testbench
===================================

// Module: clock_alarm_core
// PURPOSE
//  Receiving end of the time/alarm adjust interface driven by time_set. Holds
//  the running BCD time (hh:mm:ss, 24 h) and the BCD alarm time (hh:mm).
//  Advances on a 1 Hz enable and applies the four set-mode increment strobes.
//  Raises the alarm ring and the hourly chime for the display/buzzer stage.
// PARAMETERS
//  SYNC_STAGES   2   flops in each adjust-input synchroniser (>=2)
//  RING_SECONDS  60  ring length in tick_1hz periods (1..255)
// PORTS
//  clk        in   1  system clock; all state on posedge
//  rst_n      in   1  asynchronous active-low reset
//  tick_1hz   in   1  one-clk-wide enable, once per second
//  inc_min_t  in   1  async level from time_set count1: time minute +1 per rising edge
//  inc_hour_t in   1  async level from time_set counta: time hour +1 per rising edge
//  inc_min_a  in   1  async level from time_set count2: alarm minute +1 per rising edge
//  inc_hour_a in   1  async level from time_set countb: alarm hour +1 per rising edge
//  alarm_en   in   1  level; 1 = alarm armed
//  ring_stop  in   1  one-clk pulse; cancels an active ring
//  t_hour     out  8  time hour, BCD {tens,units}, 00..23
//  t_min      out  8  time minute, BCD, 00..59
//  t_sec      out  8  time second, BCD, 00..59
//  a_hour     out  8  alarm hour, BCD, 00..23
//  a_min      out  8  alarm minute, BCD, 00..59
//  ring       out  1  alarm sounding
//  chime      out  1  high for one tick period after each xx:00:00
// BEHAVIOUR
//  Reset (rst_n=0, async): all time/alarm regs 00, ring=0, chime=0, ring counter 0,
//   synchroniser and edge-detect flops 0 (input already high at release = no edge).
//  Adjust inputs: SYNC_STAGES-flop sync, then rising-edge detect -> 1-clk strobe.
//   Register changes on clk edge SYNC_STAGES+1 after the raw input rises. Falling edge: no effect.
//  Tick (tick_1hz=1): sec+1; 59->00 carries min+1; min 59->00 carries hour+1; hour 23->00.
//  Manual time minute strobe: min+1, 59->00, NO carry to hour; sec unchanged.
//  Manual time hour strobe: hour+1, 23->00. Alarm strobes identical on a_min/a_hour.
//  Simultaneous manual strobe and tick carry into the same field in one clk: field
//   advances by exactly 1 (no double count); sec still wraps to 00.
//  Simultaneous min and hour manual strobes: both apply, each +1, no interaction.
//  BCD: units 0..9 then tens+1; no illegal codes ever reachable.
//  Alarm FSM: IDLE -> RING when a tick makes time == a_hour:a_min:00 and alarm_en=1.
//   RING: ring=1; counter increments on each tick; RING -> IDLE when counter reaches
//   RING_SECONDS, on ring_stop, or alarm_en=0 (next clk). Counter cleared on entry.
//   Manual adjust of time/alarm into a match never triggers (tick-qualified only).
//   ring_stop in IDLE ignored. Re-trigger while RING: ignored.
//  Chime: set on the tick producing mm:ss=00:00 (carry or 23:59:59->00:00:00);
//   cleared on the next tick. Manual hour change does not chime.
//  Outputs are registered; values visible the clk after the causing event.
// TESTING
//  1 Reset to 23:59:58, 2 ticks -> t=00:00:00 after 2nd tick, chime=1 for 1 tick, then 0.
//  2 t_min=59, raise inc_min_t -> t_min=00, t_hour unchanged, update at clk SYNC_STAGES+1.
//  3 Hold inc_hour_t high through reset release -> no increment; low then high -> +1 only.
//  4 Alarm 07:30, alarm_en=1, run from 07:29:59 -> ring=1 after tick; 60 ticks later ring=0;
//    repeat with ring_stop at 5th tick -> ring=0 next clk.
//  5 Time 12:34:59, tick and inc_min_t strobe same clk -> 12:35:00 (not 12:36).
//  6 Assert rst_n=0 mid-ring at 07:30:10 -> all outputs 0/00 immediately (no clk needed).

Source files
------------

// File: rtl/clock_alarm_core.sv
// rtl/clock_alarm_core.sv - BCD time-of-day and alarm core with ring and hourly chime
module clock_alarm_core #(
    parameter int SYNC_STAGES  = 2,
    parameter int RING_SECONDS = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       inc_min_t,
    input  logic       inc_hour_t,
    input  logic       inc_min_a,
    input  logic       inc_hour_a,
    input  logic       alarm_en,
    input  logic       ring_stop,
    output logic [7:0] t_hour,
    output logic [7:0] t_min,
    output logic [7:0] t_sec,
    output logic [7:0] a_hour,
    output logic [7:0] a_min,
    output logic       ring,
    output logic       chime
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RING = 1'b1;
    localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

    logic [3:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [4];
    logic [3:0]             sync_last;
    logic [3:0]             prev_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic [3:0]             stb;

    logic       sec_wrap;
    logic       min_carry;
    logic       min_step;
    logic       hour_step;
    logic [7:0] sec_nx;
    logic [7:0] min_nx;
    logic [7:0] hour_nx;
    logic       match;

    logic [0:0] state_q;
    logic [7:0] cnt_q;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign raw = {inc_hour_a, inc_min_a, inc_hour_t, inc_min_t};

    // prime_q keeps the edge detector quiet until prev_q holds a real post-reset sample,
    // so an input already high at reset release is not taken as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) sync_q[i] <= '0;
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                prev_q[i] <= sync_q[i][SYNC_STAGES-1];
            end
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_comb begin
        sync_last = '0;
        for (int i = 0; i < 4; i++) sync_last[i] = sync_q[i][SYNC_STAGES-1];
    end

    assign stb = sync_last & ~prev_q & {4{prime_q[SYNC_STAGES]}};

    // A manual strobe and a tick carry into the same field merge into a single +1.
    assign sec_wrap  = tick_1hz && (t_sec == 8'h59);
    assign min_carry = sec_wrap && (t_min == 8'h59);
    assign min_step  = sec_wrap || stb[0];
    assign hour_step = min_carry || stb[1];
    assign sec_nx    = tick_1hz  ? bcd_inc(t_sec,  8'h59) : t_sec;
    assign min_nx    = min_step  ? bcd_inc(t_min,  8'h59) : t_min;
    assign hour_nx   = hour_step ? bcd_inc(t_hour, 8'h23) : t_hour;
    assign match     = tick_1hz && alarm_en && (sec_nx == 8'h00) &&
                       (min_nx == a_min) && (hour_nx == a_hour);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_hour <= 8'h00;
            t_min  <= 8'h00;
            t_sec  <= 8'h00;
            a_hour <= 8'h00;
            a_min  <= 8'h00;
            chime  <= 1'b0;
        end else begin
            t_sec  <= sec_nx;
            t_min  <= min_nx;
            t_hour <= hour_nx;
            if (stb[2]) a_min  <= bcd_inc(a_min,  8'h59);
            if (stb[3]) a_hour <= bcd_inc(a_hour, 8'h23);
            if (tick_1hz) chime <= min_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (match) begin
                        state_q <= ST_RING;
                        cnt_q   <= 8'd0;
                    end
                end
                default: begin
                    if (ring_stop || !alarm_en) begin
                        state_q <= ST_IDLE;
                    end else if (tick_1hz) begin
                        if (cnt_q == RING_LAST)
                            state_q <= ST_IDLE;
                        else
                            cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign ring = (state_q == ST_RING);

endmodule

// File: tb/tb_clock_alarm_core.sv
// tb/tb_clock_alarm_core.sv - randomized and directed bench for clock_alarm_core
module tb_clock_alarm_core;

    localparam int SS = 2;
    localparam int RS = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       alarm_en = 1'b0;
    logic       ring_stop = 1'b0;
    logic [3:0] raw = 4'b0000;
    logic       inc_min_t, inc_hour_t, inc_min_a, inc_hour_a;
    logic [7:0] t_hour, t_min, t_sec, a_hour, a_min;
    logic       ring, chime;

    assign inc_min_t  = raw[0];
    assign inc_hour_t = raw[1];
    assign inc_min_a  = raw[2];
    assign inc_hour_a = raw[3];

    clock_alarm_core #(.SYNC_STAGES(SS), .RING_SECONDS(RS)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .inc_min_t(inc_min_t), .inc_hour_t(inc_hour_t),
        .inc_min_a(inc_min_a), .inc_hour_a(inc_hour_a),
        .alarm_en(alarm_en), .ring_stop(ring_stop),
        .t_hour(t_hour), .t_min(t_min), .t_sec(t_sec),
        .a_hour(a_hour), .a_min(a_min), .ring(ring), .chime(chime)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: plain integer fields and a scheduled-strobe cycle per input
    int cyc;
    int due [4];
    int hold [4];
    int mh, mm, ms, mah, mam, mcnt;
    bit mring, mchime;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mh = 0; mm = 0; ms = 0; mah = 0; mam = 0; mcnt = 0;
        mring = 0; mchime = 0; cyc = 0;
        for (int i = 0; i < 4; i++) begin due[i] = -1; hold[i] = 0; end
    endtask

    task automatic model_edge();
        bit st [4];
        bit cm, ch;
        int oah, oam;
        for (int i = 0; i < 4; i++) begin
            st[i] = (due[i] == cyc);
            if (st[i]) due[i] = -1;
        end
        cm = tick_1hz && (ms == 59);
        ch = cm && (mm == 59);
        oah = mah; oam = mam;
        if (tick_1hz) ms = (ms + 1) % 60;
        if (cm || st[0]) mm = (mm + 1) % 60;
        if (ch || st[1]) mh = (mh + 1) % 24;
        if (st[2]) mam = (mam + 1) % 60;
        if (st[3]) mah = (mah + 1) % 24;
        if (tick_1hz) mchime = ch;
        if (mring) begin
            if (ring_stop || !alarm_en) mring = 0;
            else if (tick_1hz) begin
                mcnt++;
                if (mcnt == RS) mring = 0;
            end
        end else if (tick_1hz && alarm_en && ms == 0 && mm == oam && mh == oah) begin
            mring = 1;
            mcnt = 0;
        end
    endtask

    task automatic compare_all();
        check("t_hour", t_hour, bcd(mh));
        check("t_min",  t_min,  bcd(mm));
        check("t_sec",  t_sec,  bcd(ms));
        check("a_hour", a_hour, bcd(mah));
        check("a_min",  a_min,  bcd(mam));
        check("ring",   ring,   mring);
        check("chime",  chime,  mchime);
    endtask

    task automatic clk_step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        tick_1hz  = 1'b0;
        ring_stop = 1'b0;
        @(negedge clk);
        compare_all();
    endtask

    // A rise first sampled at edge cyc+1 takes effect SS edges later.
    task automatic set_raw(input int i, input bit v);
        if (v && !raw[i] && cyc >= 1) due[i] = cyc + 1 + SS;
        raw[i] = v;
    endtask

    task automatic pulse(input int i);
        set_raw(i, 1'b1);
        clk_step();
        set_raw(i, 1'b0);
        repeat (SS + 1) clk_step();
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            clk_step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clk_step();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        while (ms != s) tick_n(1);
        while (mm != m) pulse(0);
        while (mh != h) pulse(1);
    endtask

    task automatic set_alarm(input int h, input int m);
        while (mam != m) pulse(2);
        while (mah != h) pulse(3);
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_time", {t_hour, t_min, t_sec}, 24'h0);
        check("reset_ring", {ring, chime}, 2'b00);

        // midnight rollover with chime
        do_reset();
        set_time(23, 59, 58);
        tick_n(2);
        check("t1_time", {t_hour, t_min, t_sec}, 24'h000000);
        check("t1_chime_set", chime, 1'b1);
        repeat (3) clk_step();
        check("t1_chime_hold", chime, 1'b1);
        tick_n(1);
        check("t1_chime_clr", chime, 1'b0);

        // manual minute wrap without hour carry, exact latency
        while (mm != 59) pulse(0);
        set_raw(0, 1'b1);
        repeat (SS) clk_step();
        check("t2_before", t_min, 8'h59);
        clk_step();
        check("t2_wrap", t_min, 8'h00);
        check("t2_hour", t_hour, 8'h00);
        set_raw(0, 1'b0);
        repeat (3) clk_step();

        // input held high across reset release is not an edge
        raw[1] = 1'b1;
        do_reset();
        repeat (6) clk_step();
        check("t3_no_edge", t_hour, 8'h00);
        set_raw(1, 1'b0);
        repeat (2) clk_step();
        set_raw(1, 1'b1);
        repeat (SS + 2) clk_step();
        check("t3_one_inc", t_hour, 8'h01);
        set_raw(1, 1'b0);
        repeat (3) clk_step();

        // alarm ring full length
        do_reset();
        alarm_en = 1'b0;
        set_alarm(7, 30);
        set_time(7, 29, 59);
        alarm_en = 1'b1;
        clk_step();
        tick_n(1);
        check("t4_ring_on", ring, 1'b1);
        tick_n(RS - 1);
        check("t4_ring_last", ring, 1'b1);
        tick_n(1);
        check("t4_ring_off", ring, 1'b0);

        // alarm cancelled by ring_stop
        do_reset();
        alarm_en = 1'b0;
        set_alarm(7, 30);
        set_time(7, 29, 59);
        alarm_en = 1'b1;
        tick_n(1);
        check("t4b_ring_on", ring, 1'b1);
        tick_n(5);
        ring_stop = 1'b1;
        clk_step();
        check("t4b_stopped", ring, 1'b0);

        // tick carry and manual minute strobe in the same clk
        do_reset();
        set_time(12, 34, 59);
        set_raw(0, 1'b1);
        clk_step();
        set_raw(0, 1'b0);
        repeat (SS - 1) clk_step();
        tick_1hz = 1'b1;
        clk_step();
        check("t5_time", {t_hour, t_min, t_sec}, 24'h123500);
        repeat (3) clk_step();

        // asynchronous reset in the middle of a ring
        do_reset();
        alarm_en = 1'b0;
        set_alarm(7, 30);
        set_time(7, 29, 59);
        alarm_en = 1'b1;
        tick_n(11);
        check("t6_ringing", {ring, t_hour, t_min, t_sec}, {1'b1, 24'h073010});
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_time", {t_hour, t_min, t_sec, a_hour, a_min}, 40'h0);
        check("t6_async_flags", {ring, chime}, 2'b00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clk_step();

        // randomized mix of ticks, strobes, ring_stop and alarm_en
        alarm_en = 1'b1;
        set_alarm(0, 1);
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] > 0) hold[i]--;
                else if (raw[i]) begin
                    set_raw(i, 1'b0);
                    hold[i] = $urandom_range(2, 4);
                end else if ($urandom_range(0, 7) == 0) begin
                    set_raw(i, 1'b1);
                    hold[i] = $urandom_range(0, 2);
                end
            end
            tick_1hz  = ($urandom_range(0, 1) == 1);
            ring_stop = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 300) == 0) alarm_en = ~alarm_en;
            clk_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
